// File: rtl/trace_pkg.sv
// Shared types and constants for the instruction trace buffer.
// Entry layout is {pc, inst}, pc in the upper word.
package trace_pkg;

  localparam int ENTRY_W = 64;
  localparam logic [31:0] MARS_TEXT_BASE = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  function automatic entry_t mk_entry(
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop frees the head slot.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

  // Masked while empty so the output reads zero out of reset.
  assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/inst_trace_buffer.sv
// Post-mortem trace of (pc, inst) pairs from a single-cycle CPU.
// Arms on command, triggers on a pc match, drains through valid/ready.
module inst_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CAPTURE_LEN = 16,
  parameter int SKIP_REPEAT = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        arm,
  input  logic        abort,
  input  logic [31:0] trig_pc,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic [1:0]  state,
  output logic [$clog2(CAPTURE_LEN+1)-1:0] rec_count,
  output logic        overflow
);

  localparam int CW = $clog2(CAPTURE_LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(CAPTURE_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(CAPTURE_LEN - 1);

  state_e        state_q, state_d;
  logic [31:0]   trig_q, trig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          last_vld_q, last_vld_d;

  logic   flush;
  logic   rec;
  logic   full;
  logic   empty;
  logic   pop_ok;
  logic   hit_trig;
  logic   is_rep;
  entry_t wr_entry;

  assign wr_entry = mk_entry(pc, inst);
  assign pop_ok   = rd_ready & ~empty;
  assign hit_trig = (pc == trig_q);
  assign is_rep   = (SKIP_REPEAT != 0) && last_vld_q &&
                    (pc == last_pc_q);

  always_comb begin
    state_d    = state_q;
    trig_d     = trig_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    flush      = 1'b0;
    rec        = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d    = ST_ARMED;
            trig_d     = trig_pc;
            flush      = 1'b1;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            last_vld_d = 1'b0;
          end
        end
        ST_ARMED: begin
          if (hit_trig) begin
            rec     = 1'b1;
            state_d = (CAPTURE_LEN == 1) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (cnt_q >= LEN_C) begin
            state_d = ST_DONE;
          end else if (!is_rep) begin
            rec = 1'b1;
            if (cnt_q == LAST_C) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A dropped entry still counts and still updates the repeat filter.
    if (rec) begin
      last_pc_d  = pc;
      last_vld_d = 1'b1;
      if (cnt_q < LEN_C) cnt_d = cnt_q + 1'b1;
      if (full && !pop_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      trig_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (reset),
    .flush (flush),
    .push  (rec),
    .pop   (rd_ready),
    .wdata (wr_entry),
    .full  (full),
    .empty (empty),
    .rdata (rd_data)
  );

  assign rd_valid  = ~empty;
  assign state     = state_q;
  assign rec_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Directed scoreboard bench for inst_trace_buffer.
// Three instances: default, shallow FIFO, repeat filter disabled.
module tb_inst_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, inst, trig;
  logic        arm, abort;
  logic [2:0]  rdy, vld, ovf;
  logic [63:0] rd0, rd1, rd2;
  logic [1:0]  st0, st1, st2;
  logic [4:0]  rc0, rc2;
  logic [3:0]  rc1;
  logic [31:0] p;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_trace_buffer #(.DEPTH(16), .CAPTURE_LEN(16), .SKIP_REPEAT(1)) u0 (
    .clk_in(clk), .reset(reset), .pc(pc), .inst(inst),
    .arm(arm), .abort(abort), .trig_pc(trig),
    .rd_valid(vld[0]), .rd_ready(rdy[0]), .rd_data(rd0),
    .state(st0), .rec_count(rc0), .overflow(ovf[0])
  );

  inst_trace_buffer #(.DEPTH(4), .CAPTURE_LEN(8), .SKIP_REPEAT(1)) u1 (
    .clk_in(clk), .reset(reset), .pc(pc), .inst(inst),
    .arm(arm), .abort(abort), .trig_pc(trig),
    .rd_valid(vld[1]), .rd_ready(rdy[1]), .rd_data(rd1),
    .state(st1), .rec_count(rc1), .overflow(ovf[1])
  );

  inst_trace_buffer #(.DEPTH(16), .CAPTURE_LEN(16), .SKIP_REPEAT(0)) u2 (
    .clk_in(clk), .reset(reset), .pc(pc), .inst(inst),
    .arm(arm), .abort(abort), .trig_pc(trig),
    .rd_valid(vld[2]), .rd_ready(rdy[2]), .rd_data(rd2),
    .state(st2), .rec_count(rc2), .overflow(ovf[2])
  );

  function automatic logic [31:0] instf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a, instf(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setpc(input logic [31:0] a);
    pc   = a;
    inst = instf(a);
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_vld(input int id);
    return vld[id];
  endfunction

  function automatic logic [63:0] get_data(input int id);
    if (id == 0) return rd0;
    if (id == 1) return rd1;
    return rd2;
  endfunction

  function automatic int qsize(input int id);
    if (id == 0) return q0.size();
    if (id == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic logic [63:0] qpop(input int id);
    if (id == 0) return q0.pop_front();
    if (id == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  task automatic drain(input int id, input string tag);
    rdy[id] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (get_vld(id) !== 1'b1) break;
      if (qsize(id) == 0)
        chk({tag, "_extra"}, 64'(get_vld(id)), 64'd0);
      else
        chk(tag, get_data(id), qpop(id));
      step();
    end
    rdy[id] = 1'b0;
    chk({tag, "_left"}, 64'(qsize(id)), 64'd0);
    chk({tag, "_vld"}, 64'(get_vld(id)), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    arm   = 1'b0;
    abort = 1'b0;
    trig  = '0;
    rdy   = '0;
    setpc(32'h0);
    step();
    step();
    chk("rst_state", 64'(st0), 64'd0);
    chk("rst_vld", 64'(vld[0]), 64'd0);
    chk("rst_data", rd0, 64'd0);
    chk("rst_cnt", 64'(rc0), 64'd0);
    chk("rst_ovf", 64'(ovf[0]), 64'd0);
    reset = 1'b1;
    step();

    // Trigger mid-stream; the shallow instance overflows.
    arm  = 1'b1;
    trig = 32'h0040_0008;
    setpc(32'h0040_0000);
    step();
    arm = 1'b0;
    chk("t2_armed", 64'(st0), 64'd1);
    chk("t2_empty", 64'(vld[0]), 64'd0);
    for (int i = 0; i < 24; i++) begin
      if (i == 1) chk("t2_pre", 64'(vld[0]), 64'd0);
      if (i == 2) chk("t2_first", rd0, ent(32'h0040_0008));
      p = 32'h0040_0004 + 32'(4 * i);
      setpc(p);
      if (p >= 32'h0040_0008 && p < 32'h0040_0048) q0.push_back(ent(p));
      if (p >= 32'h0040_0008 && p < 32'h0040_0018) q1.push_back(ent(p));
      step();
    end
    chk("t2_state", 64'(st0), 64'd3);
    chk("t2_cnt", 64'(rc0), 64'd16);
    chk("t2_ovf", 64'(ovf[0]), 64'd0);
    chk("t3_state", 64'(st1), 64'd3);
    chk("t3_cnt", 64'(rc1), 64'd8);
    chk("t3_ovf", 64'(ovf[1]), 64'd1);

    // Arm and abort together from DONE.
    arm   = 1'b1;
    abort = 1'b1;
    trig  = 32'h0040_0100;
    step();
    arm   = 1'b0;
    abort = 1'b0;
    chk("t6_state", 64'(st0), 64'd0);
    chk("t6_vld", 64'(vld[0]), 64'd1);
    chk("t6_head", rd0, q0[0]);
    chk("t6_ovf_kept", 64'(ovf[1]), 64'd1);
    drain(0, "t2_drain");
    drain(1, "t3_drain");
    chk("t6_u2_full", 64'(vld[2]), 64'd1);

    // Held pc: filter on vs off; this arm also flushes u2.
    arm  = 1'b1;
    trig = 32'h0040_0010;
    setpc(32'h0040_0000);
    step();
    arm = 1'b0;
    chk("t6_flush_vld", 64'(vld[2]), 64'd0);
    chk("t6_flush_cnt", 64'(rc2), 64'd0);
    chk("t3_ovf_clr", 64'(ovf[1]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      setpc(32'h0040_0010);
      q2.push_back(ent(32'h0040_0010));
      if (i == 0) begin
        q0.push_back(ent(32'h0040_0010));
        q1.push_back(ent(32'h0040_0010));
      end
      step();
    end
    chk("t4_cnt_skip", 64'(rc0), 64'd1);
    chk("t4_cnt_skip1", 64'(rc1), 64'd1);
    chk("t4_cnt_noskip", 64'(rc2), 64'd5);
    chk("t4_capture", 64'(st0), 64'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort", 64'(st0), 64'd0);
    drain(0, "t4_drain0");
    drain(1, "t4_drain1");
    drain(2, "t4_drain2");

    // Continuous drain during capture.
    arm  = 1'b1;
    trig = 32'h0040_0200;
    setpc(32'h0040_01F8);
    rdy[0] = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("t5_vld", 64'(vld[0]), 64'(q0.size() != 0));
      if (vld[0] === 1'b1 && q0.size() != 0)
        chk("t5_data", rd0, q0.pop_front());
      p = 32'h0040_01FC + 32'(4 * i);
      setpc(p);
      if (p >= 32'h0040_0200 && p < 32'h0040_0240) q0.push_back(ent(p));
      step();
    end
    rdy[0] = 1'b0;
    chk("t5_left", 64'(q0.size()), 64'd0);
    chk("t5_state", 64'(st0), 64'd3);
    chk("t5_cnt", 64'(rc0), 64'd16);
    chk("t5_ovf", 64'(ovf[0]), 64'd0);

    // Reset in the middle of a capture.
    arm  = 1'b1;
    trig = 32'h0040_0300;
    setpc(32'h0040_0300);
    step();
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setpc(32'h0040_0300 + 32'(4 * i));
      step();
    end
    chk("t1_pre_cnt", 64'(rc0), 64'd3);
    chk("t1_pre_state", 64'(st0), 64'd2);
    chk("t1_pre_vld", 64'(vld[0]), 64'd1);
    reset = 1'b0;
    #1;
    chk("t1_state", 64'(st0), 64'd0);
    chk("t1_vld", 64'(vld[0]), 64'd0);
    chk("t1_data", rd0, 64'd0);
    chk("t1_cnt", 64'(rc0), 64'd0);
    chk("t1_ovf", 64'(ovf[0]), 64'd0);
    chk("t1_state1", 64'(st1), 64'd0);
    #1;
    reset = 1'b1;
    step();
    chk("t1_post_vld", 64'(vld[0]), 64'd0);
    chk("t1_post_state", 64'(st0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
